// File: rtl/fifo_pkg.sv
// Shared types and helpers for the flexible synchronous FIFO family.
package fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    function automatic int fifo_depth(input int add_width);
        return 1 << add_width;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Register-array storage for the FIFO.
// It has one synchronous write port and one asynchronous read port.
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int ADD_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  w_en,
    input  logic [ADD_WIDTH-1:0]  w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic [ADD_WIDTH-1:0]  r_addr,
    output logic [DATA_WIDTH-1:0] r_data
);

    localparam int DEPTH = 1 << ADD_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // NOTE: storage has no reset; the pointers alone decide which words are valid.
    always_ff @(posedge clk) begin
        if (w_en) begin
            mem_q[w_addr] <= w_data;
        end
    end

    assign r_data = mem_q[r_addr];

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with occupancy count, almost flags, error pulses, flush,
// and a choice of registered (STD) or first-word-fall-through read.
import fifo_pkg::*;

module sync_fifo_flex #(
    parameter int         DATA_WIDTH = 8,
    parameter int         ADD_WIDTH  = 4,
    parameter int         AF_THRESH  = fifo_depth(ADD_WIDTH) - 2,
    parameter int         AE_THRESH  = 2,
    parameter fifo_mode_e MODE       = FIFO_STD
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADD_WIDTH:0]    count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                 DEPTH   = fifo_depth(ADD_WIDTH);
    localparam logic [ADD_WIDTH:0] PTR_ONE = {{ADD_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADD_WIDTH:0] AF_LVL  = AF_THRESH[ADD_WIDTH:0];
    localparam logic [ADD_WIDTH:0] AE_LVL  = AE_THRESH[ADD_WIDTH:0];

    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("sync_fifo_flex: AF_THRESH out of range 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo_flex: AE_THRESH out of range 0..DEPTH-1");
    end

    logic [ADD_WIDTH:0]    w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
    logic [DATA_WIDTH-1:0] r_data_q, r_data_d, mem_rdata;
    logic                  r_valid_q, r_valid_d;
    logic                  overflow_q, overflow_d, underflow_q, underflow_d;
    logic                  rd_acc, wr_acc;

    // The extra MSB on each pointer tells a full FIFO apart from an empty one.
    assign count        = w_ptr_q - r_ptr_q;
    assign empty        = (w_ptr_q == r_ptr_q);
    assign full         = (w_ptr_q[ADD_WIDTH-1:0] == r_ptr_q[ADD_WIDTH-1:0])
                          && (w_ptr_q[ADD_WIDTH] != r_ptr_q[ADD_WIDTH]);
    assign almost_full  = (count >= AF_LVL);
    assign almost_empty = (count <= AE_LVL);

    assign rd_acc = rd & ~empty & ~flush;
    assign wr_acc = wr & (~full | rd_acc) & ~flush;

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADD_WIDTH  (ADD_WIDTH)
    ) u_mem (
        .clk    (clk),
        .w_en   (wr_acc),
        .w_addr (w_ptr_q[ADD_WIDTH-1:0]),
        .w_data (w_data),
        .r_addr (r_ptr_q[ADD_WIDTH-1:0]),
        .r_data (mem_rdata)
    );

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_ptr_d     = w_ptr_q;
        r_ptr_d     = r_ptr_q;
        r_data_d    = r_data_q;
        r_valid_d   = rd_acc;
        overflow_d  = wr & ~wr_acc & ~flush;
        underflow_d = rd & ~rd_acc & ~flush;
        if (rd_acc) begin
            r_ptr_d  = r_ptr_q + PTR_ONE;
            r_data_d = mem_rdata;
        end
        if (wr_acc) begin
            w_ptr_d = w_ptr_q + PTR_ONE;
        end
        if (flush) begin
            w_ptr_d = '0;
            r_ptr_d = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_ptr_q     <= '0;
            r_ptr_q     <= '0;
            r_data_q    <= '0;
            r_valid_q   <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            w_ptr_q     <= w_ptr_d;
            r_ptr_q     <= r_ptr_d;
            r_data_q    <= r_data_d;
            r_valid_q   <= r_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign r_data    = (MODE == FIFO_FWFT) ? mem_rdata : r_data_q;
    assign r_valid   = (MODE == FIFO_FWFT) ? ~empty : r_valid_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Scoreboard bench: an STD and an FWFT instance share stimulus and are checked against a queue model.
import fifo_pkg::*;

module tb_sync_fifo_flex;

    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int AE    = 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          wr = 1'b0;
    logic          rd = 1'b0;
    logic [DW-1:0] w_data = '0;

    logic [DW-1:0] s_r_data, f_r_data;
    logic          s_r_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic          f_r_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [AW:0]   s_count, f_count;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] model_q[$];
    logic [DW-1:0] exp_q[$];
    bit            exp_valid = 0;
    bit            exp_ovf   = 0;
    bit            exp_unf   = 0;

    always #5 clk = ~clk;

    sync_fifo_flex #(
        .DATA_WIDTH (DW), .ADD_WIDTH (AW), .AF_THRESH (AF), .AE_THRESH (AE), .MODE (FIFO_STD)
    ) u_std (
        .clk (clk), .reset (reset), .flush (flush), .wr (wr), .w_data (w_data), .rd (rd),
        .r_data (s_r_data), .r_valid (s_r_valid), .full (s_full), .empty (s_empty),
        .almost_full (s_af), .almost_empty (s_ae), .count (s_count),
        .overflow (s_ovf), .underflow (s_unf)
    );

    sync_fifo_flex #(
        .DATA_WIDTH (DW), .ADD_WIDTH (AW), .AF_THRESH (AF), .AE_THRESH (AE), .MODE (FIFO_FWFT)
    ) u_fwft (
        .clk (clk), .reset (reset), .flush (flush), .wr (wr), .w_data (w_data), .rd (rd),
        .r_data (f_r_data), .r_valid (f_r_valid), .full (f_full), .empty (f_empty),
        .almost_full (f_af), .almost_empty (f_ae), .count (f_count),
        .overflow (f_ovf), .underflow (f_unf)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus (called just after a falling edge) and update the model at the edge.
    task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit f);
        bit racc, wacc;
        int n;
        wr = w; w_data = d; rd = r; flush = f;
        n    = model_q.size();
        racc = r && (n > 0) && !f;
        wacc = w && ((n < DEPTH) || racc) && !f;
        @(posedge clk);
        exp_ovf   = w && !wacc && !f;
        exp_unf   = r && !racc && !f;
        exp_valid = racc;
        if (f) begin
            model_q.delete();
        end else begin
            if (racc) exp_q.push_back(model_q.pop_front());
            if (wacc) model_q.push_back(d);
        end
        @(negedge clk);
        wr = 0; rd = 0; flush = 0;
    endtask

    // Monitor: compares both instances against the model on every falling edge.
    always @(negedge clk) begin
        int n;
        logic [DW-1:0] e;
        n = model_q.size();
        check("std_count", int'(s_count), n);
        check("std_full", int'(s_full), int'(n == DEPTH));
        check("std_empty", int'(s_empty), int'(n == 0));
        check("std_almost_full", int'(s_af), int'(n >= AF));
        check("std_almost_empty", int'(s_ae), int'(n <= AE));
        check("std_overflow", int'(s_ovf), int'(exp_ovf));
        check("std_underflow", int'(s_unf), int'(exp_unf));
        check("std_r_valid", int'(s_r_valid), int'(exp_valid));
        if (s_r_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("std_r_data", int'(s_r_data), int'(e));
        end
        check("fwft_count", int'(f_count), n);
        check("fwft_full", int'(f_full), int'(n == DEPTH));
        check("fwft_empty", int'(f_empty), int'(n == 0));
        check("fwft_almost_full", int'(f_af), int'(n >= AF));
        check("fwft_almost_empty", int'(f_ae), int'(n <= AE));
        check("fwft_overflow", int'(f_ovf), int'(exp_ovf));
        check("fwft_underflow", int'(f_unf), int'(exp_unf));
        check("fwft_r_valid", int'(f_r_valid), int'(n > 0));
        if (n > 0) check("fwft_r_data", int'(f_r_data), int'(model_q[0]));
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_std_r_data", int'(s_r_data), 0);
        reset = 0;

        // 1: fill, then overflow
        step(1, 8'hA1, 0, 0);
        step(1, 8'hB2, 0, 0);
        step(1, 8'hC3, 0, 0);
        step(1, 8'hD4, 0, 0);
        step(1, 8'hE5, 0, 0);
        step(0, 8'h00, 0, 0);

        // 2: drain, then underflow
        for (int i = 0; i < 5; i++) step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 0);

        // 3: full FIFO with simultaneous wr+rd across the pointer wrap
        for (int i = 0; i < 4; i++) step(1, 8'h20 + 8'(i), 0, 0);
        for (int i = 0; i < 6; i++) step(1, 8'h10 + 8'(i), 1, 0);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0);

        // 4: single word into empty, visible on FWFT without rd
        step(1, 8'h5A, 0, 0);
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 0);

        // 5: flush with a concurrent write
        for (int i = 0; i < 3; i++) step(1, 8'h30 + 8'(i), 0, 0);
        step(1, 8'h99, 1, 1);
        step(0, 8'h00, 0, 0);

        // 6: asynchronous reset mid-burst
        step(1, 8'h41, 0, 0);
        step(1, 8'h42, 0, 0);
        #2;
        reset = 1;
        model_q.delete();
        exp_q.delete();
        exp_valid = 0; exp_ovf = 0; exp_unf = 0;
        #1;
        check("async_rst_count", int'(s_count), 0);
        check("async_rst_empty", int'(s_empty), 1);
        check("async_rst_almost_empty", int'(s_ae), 1);
        check("async_rst_r_data", int'(s_r_data), 0);
        check("async_rst_fwft_count", int'(f_count), 0);
        @(negedge clk);
        reset = 0;
        step(1, 8'h77, 0, 0);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 0);

        // Randomised traffic with occasional flush
        for (int i = 0; i < 600; i++) begin
            step(bit'($urandom_range(0, 99) < 55), 8'($urandom), bit'($urandom_range(0, 99) < 50),
                 bit'($urandom_range(0, 39) == 0));
        end
        for (int i = 0; i < DEPTH + 1; i++) step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
